// File: rtl/lfsr_scrambler_if.sv
// lfsr_scrambler_if: handshake, data and control bundle for lfsr_scrambler.
// SCRAMBLER_BYPASS_EN adds bypass_i.
interface lfsr_scrambler_if #(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 7
) ();
  logic              mode_i;
  logic              dir_i;
  logic              seed_load_i;
  logic [LFSR_W-1:0] seed_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              frame_start_o;
`ifdef SCRAMBLER_BYPASS_EN
  logic              bypass_i;
`endif
  modport slave (
`ifdef SCRAMBLER_BYPASS_EN
    input  bypass_i,
`endif
    input  mode_i, dir_i, seed_load_i, seed_i, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, frame_start_o
  );
  modport master (
`ifdef SCRAMBLER_BYPASS_EN
    output bypass_i,
`endif
    output mode_i, dir_i, seed_load_i, seed_i, data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, frame_start_o
  );
endinterface

// File: rtl/lfsr_scrambler.sv
// lfsr_scrambler: DATA_W-bit-per-clock additive/multiplicative LFSR scrambler with one output register.
// SCRAMBLER_BYPASS_EN adds bypass_i (pass word through, freeze LFSR, frame counter still advances).
module lfsr_scrambler #(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] POLY      = 7'h60,
  parameter logic [LFSR_W-1:0] SEED      = 7'h7F,
  parameter int                FRAME_LEN = 64
) (
  input logic             clk_i,
  input logic             rstn_i,
  lfsr_scrambler_if.slave bus
);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  logic [LFSR_W-1:0] state_q, state_d, lfsr_nx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, scr;
  logic              first_q, first_d, valid_q, valid_d, fs_q, fs_d;
  logic              rdy, acc, wrap, byp, fb, x;
`ifdef SCRAMBLER_BYPASS_EN
  assign byp = bus.bypass_i;
`else
  assign byp = 1'b0;
`endif
  assign rdy = (!valid_q || bus.ready_i) && !bus.seed_load_i;
  assign acc = bus.valid_i && rdy;
  // Serial bit order unrolled: bit 0 sees the current state, each later bit the shifted one.
  always_comb begin
    lfsr_nx = state_q;
    scr     = '0;
    fb      = 1'b0;
    x       = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      fb      = ^(lfsr_nx & POLY);
      scr[i]  = bus.data_i[i] ^ fb;
      x       = bus.mode_i ? (bus.dir_i ? bus.data_i[i] : scr[i]) : fb;
      lfsr_nx = {lfsr_nx[LFSR_W-2:0], x};
    end
  end
  always_comb begin
    wrap    = (FRAME_LEN != 0) && (cnt_q == CW'(FRAME_LEN - 1));
    cnt_d   = bus.seed_load_i ? '0 : !acc ? cnt_q : (wrap || FRAME_LEN == 0) ? '0 : cnt_q + 1'b1;
    state_d = bus.seed_load_i ? bus.seed_i :
              (acc && !byp) ? ((wrap && !bus.mode_i) ? SEED : lfsr_nx) : state_q;
    first_d = bus.seed_load_i ? 1'b1 : acc ? 1'b0 : first_q;
    valid_d = acc || (valid_q && !bus.ready_i);
    data_d  = acc ? (byp ? bus.data_i : scr) : data_q;
    fs_d    = acc ? ((FRAME_LEN == 0) ? first_q : (cnt_q == '0)) : fs_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= SEED;
      cnt_q   <= '0;
      first_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
    end
  end
  assign bus.ready_o       = rdy;
  assign bus.valid_o       = valid_q;
  assign bus.data_o        = data_q;
  assign bus.frame_start_o = fs_q;
endmodule

// File: tb/tb_lfsr_scrambler.sv
// tb_lfsr_scrambler: random and directed checks against a serial-history reference model.
module tb_lfsr_scrambler;
  localparam int       DW   = 8;
  localparam int       LW   = 7;
  localparam int       FL   = 64;
  localparam bit [6:0] POLY = 7'h60;
  localparam bit [6:0] SEED = 7'h7F;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  lfsr_scrambler_if #(.DATA_W(DW), .LFSR_W(LW)) if_a ();
  lfsr_scrambler_if #(.DATA_W(DW), .LFSR_W(LW)) if_f ();
  lfsr_scrambler_if #(.DATA_W(DW), .LFSR_W(LW)) if_s ();
  lfsr_scrambler_if #(.DATA_W(DW), .LFSR_W(LW)) if_d ();
  lfsr_scrambler #(.FRAME_LEN(FL)) u_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));
  lfsr_scrambler #(.FRAME_LEN(4))  u_f (.clk_i(clk), .rstn_i(rstn), .bus(if_f));
  lfsr_scrambler #(.FRAME_LEN(FL)) u_s (.clk_i(clk), .rstn_i(rstn), .bus(if_s));
  lfsr_scrambler #(.FRAME_LEN(FL)) u_d (.clk_i(clk), .rstn_i(rstn), .bus(if_d));
  assign if_d.valid_i = if_s.valid_o;
  assign if_d.data_i  = if_s.data_o;
  assign if_s.ready_i = if_d.ready_o;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: the LFSR is the history of shifted-in bits; feedback taps look back k+1 bits.
  bit         hist[$];
  int         widx;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_fs;
  function automatic void m_load(input logic [6:0] s);
    hist.delete();
    for (int k = LW - 1; k >= 0; k--) hist.push_back(s[k]);
  endfunction
  function automatic logic [7:0] m_word(input logic [7:0] din, input logic mode, input logic dir);
    logic [7:0] o;
    logic [6:0] taps;
    bit fb, x;
    taps = POLY;
    o = '0;
    for (int i = 0; i < DW; i++) begin
      fb = 1'b0;
      for (int k = 0; k < LW; k++) if (taps[k]) fb ^= hist[hist.size() - 1 - k];
      o[i] = din[i] ^ fb;
      x = mode ? (dir ? din[i] : o[i]) : fb;
      hist.push_back(x);
      if (hist.size() > 32) void'(hist.pop_front());
    end
    return o;
  endfunction
  function automatic void m_reset();
    m_load(SEED);
    widx = 0;
    m_valid = 1'b0;
    m_data = '0;
    m_fs = 1'b0;
  endfunction
  task automatic step_a(input logic v, input logic [7:0] d, input logic m, input logic dr,
                        input logic sl, input logic [6:0] sd, input logic rdy);
    logic exp_rdy, acc;
    @(negedge clk);
    if_a.valid_i = v; if_a.data_i = d; if_a.mode_i = m; if_a.dir_i = dr;
    if_a.seed_load_i = sl; if_a.seed_i = sd; if_a.ready_i = rdy;
    #1;
    exp_rdy = (!m_valid || rdy) && !sl;
    chk("ready_o", if_a.ready_o, exp_rdy);
    chk("valid_o", if_a.valid_o, m_valid);
    if (m_valid) begin
      chk("data_o", if_a.data_o, m_data);
      chk("frame_start_o", if_a.frame_start_o, m_fs);
    end
    acc = v && exp_rdy;
    if (sl) begin
      m_load(sd);
      widx = 0;
    end else if (acc) begin
      m_data = m_word(d, m, dr);
      m_fs = (widx % FL) == 0;
      if (!m && (widx % FL) == FL - 1) m_load(SEED);
      widx++;
    end
    m_valid = acc || (m_valid && !rdy);
  endtask
  logic [7:0] f_out[5];
  logic       f_fs[5];
  int         nf = 0;
  logic [7:0] sent[200];
  int         ns = 0;
  int         rt_n = 0;
  bit         rt_on = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rt_on && if_d.valid_o) begin
      if (rt_n >= 2 && rt_n < 200) chk("round_trip", if_d.data_o, sent[rt_n]);
      rt_n++;
    end
  end
  initial begin
    {if_a.valid_i, if_a.data_i, if_a.mode_i, if_a.dir_i, if_a.seed_load_i, if_a.seed_i, if_a.ready_i} = '0;
    {if_f.valid_i, if_f.data_i, if_f.mode_i, if_f.dir_i, if_f.seed_load_i, if_f.seed_i, if_f.ready_i} = '0;
    {if_s.valid_i, if_s.data_i, if_s.mode_i, if_s.dir_i, if_s.seed_load_i, if_s.seed_i} = '0;
    {if_d.mode_i, if_d.dir_i, if_d.seed_load_i, if_d.seed_i, if_d.ready_i} = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst valid_o", if_a.valid_o, 1'b0);
    chk("rst data_o", if_a.data_o, 8'h00);
    chk("rst frame_start_o", if_a.frame_start_o, 1'b0);
    chk("rst ready_o", if_a.ready_o, 1'b1);
    rstn = 1'b1;
    step_a(1, 8'h00, 0, 0, 0, 7'h00, 1);
    @(posedge clk); #1;
    chk("prbs first word", if_a.data_o, 8'h40);
    chk("prbs first fs", if_a.frame_start_o, 1'b1);
    repeat (3) step_a(1, 8'h00, 0, 0, 0, 7'h00, 1);
    repeat (3) step_a(1, 8'($urandom), 1, 0, 0, 7'h00, 0);
    repeat (4) step_a(1, 8'($urandom), 1, 0, 0, 7'h00, 1);
    step_a(1, 8'h00, 0, 0, 1, 7'h7F, 1);
    step_a(1, 8'h00, 0, 0, 0, 7'h00, 1);
    @(posedge clk); #1;
    chk("seed load word", if_a.data_o, 8'h40);
    chk("seed load fs", if_a.frame_start_o, 1'b1);
    for (int i = 0; i < 500; i++)
      step_a(($urandom % 4) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
             ($urandom % 60) == 0, 7'($urandom), ($urandom % 4) != 0);
    step_a(1, 8'h00, 0, 0, 0, 7'h00, 0);
    @(posedge clk); #2;
    rstn = 1'b0;
    if_a.valid_i = 1'b0;
    #1;
    chk("async rst valid_o", if_a.valid_o, 1'b0);
    chk("async rst data_o", if_a.data_o, 8'h00);
    chk("async rst fs", if_a.frame_start_o, 1'b0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    step_a(1, 8'h00, 0, 0, 0, 7'h00, 1);
    @(posedge clk); #1;
    chk("post rst word", if_a.data_o, 8'h40);
    step_a(0, 8'h00, 0, 0, 0, 7'h00, 1);
    @(negedge clk);
    if_f.valid_i = 1'b1; if_f.ready_i = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (if_f.valid_o && nf < 5) begin
        f_out[nf] = if_f.data_o;
        f_fs[nf] = if_f.frame_start_o;
        nf++;
      end
    end
    if_f.valid_i = 1'b0;
    chk("frame words seen", nf, 5);
    chk("frame w0 data", f_out[0], 8'h40);
    chk("frame w4 data", f_out[4], 8'h40);
    chk("frame w0 fs", f_fs[0], 1'b1);
    for (int i = 1; i < 4; i++) chk("frame mid fs", f_fs[i], 1'b0);
    chk("frame w4 fs", f_fs[4], 1'b1);
    @(negedge clk);
    if_d.mode_i = 1; if_d.dir_i = 1; if_d.ready_i = 1; if_d.seed_i = 7'h00; if_d.seed_load_i = 1;
    if_s.mode_i = 1; if_s.dir_i = 0;
    @(negedge clk);
    if_d.seed_load_i = 0;
    rt_on = 1'b1;
    for (int c = 0; c < 2000 && ns < 200; c++) begin
      @(negedge clk);
      if_s.valid_i = ($urandom % 5) != 0;
      if_s.data_i = 8'($urandom);
      #1;
      if (if_s.valid_i && if_s.ready_o) begin
        sent[ns] = if_s.data_i;
        ns++;
      end
    end
    @(negedge clk);
    if_s.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("round trip words", rt_n, 200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
